// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encodings and the control-word layout.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1     = 6'b000001;
  localparam logic [5:0] T2     = 6'b000010;
  localparam logic [5:0] T3     = 6'b000100;
  localparam logic [5:0] T4     = 6'b001000;
  localparam logic [5:0] T5     = 6'b010000;
  localparam logic [5:0] T6     = 6'b100000;
  localparam logic [5:0] T_HALT = 6'b000000;

  // Control-word bit order, MSB first: cp ep lm ce li ei la ea su eu lb lo
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  typedef logic [11:0] cw_t;

  // Active-low strobes (lm ce li la lb lo) high, everything else low
  localparam cw_t IDLE_CW = 12'h3A3;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// Six-bit one-hot rotate; hold_i freezes the ring (used while halted).
module ring_counter
  import sap1_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       hold_i,
  output logic [5:0] ring_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ring_o <= T1;
    end else if (!hold_i) begin
      ring_o <= {ring_o[4:0], ring_o[5]};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: T1..T6 ring plus opcode decode into the 12-bit control word.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] opcode_i,
  output logic       cp_o,
  output logic       ep_o,
  output logic       lm_o,
  output logic       ce_o,
  output logic       li_o,
  output logic       ei_o,
  output logic       la_o,
  output logic       ea_o,
  output logic       su_o,
  output logic       eu_o,
  output logic       lb_o,
  output logic       lo_o,
  output logic       hlt_o,
  output logic [5:0] t_state_o
);

  logic [5:0] ring;
  logic       halt_q;
  logic       halt_entry;
  cw_t        cw;

  assign halt_entry = (ring == T4) && (opcode_i == OP_HLT) && !halt_q;

  ring_counter u_ring (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .hold_i (halt_q | halt_entry),
    .ring_o (ring)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      halt_q <= 1'b0;
    end else if (halt_entry) begin
      halt_q <= 1'b1;
    end
  end

  // rstn_i gates the decode so MAR never sees an lm strobe while reset is held
  always_comb begin
    cw = IDLE_CW;
    if (rstn_i && !halt_q) begin
      case (ring)
        T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b0; end
        T2: cw[CW_CP] = 1'b1;
        T3: begin cw[CW_CE] = 1'b0; cw[CW_LI] = 1'b0; end
        T4: begin
          case (opcode_i)
            OP_LDA, OP_ADD, OP_SUB: begin cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b0; end
            OP_OUT:                 begin cw[CW_EA] = 1'b1; cw[CW_LO] = 1'b0; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode_i)
            OP_LDA:         begin cw[CW_CE] = 1'b0; cw[CW_LA] = 1'b0; end
            OP_ADD, OP_SUB: begin cw[CW_CE] = 1'b0; cw[CW_LB] = 1'b0; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode_i)
            OP_ADD: begin cw[CW_EU] = 1'b1; cw[CW_LA] = 1'b0; end
            OP_SUB: begin cw[CW_EU] = 1'b1; cw[CW_SU] = 1'b1; cw[CW_LA] = 1'b0; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign cp_o = cw[CW_CP];
  assign ep_o = cw[CW_EP];
  assign lm_o = cw[CW_LM];
  assign ce_o = cw[CW_CE];
  assign li_o = cw[CW_LI];
  assign ei_o = cw[CW_EI];
  assign la_o = cw[CW_LA];
  assign ea_o = cw[CW_EA];
  assign su_o = cw[CW_SU];
  assign eu_o = cw[CW_EU];
  assign lb_o = cw[CW_LB];
  assign lo_o = cw[CW_LO];

  assign hlt_o     = halt_q;
  assign t_state_o = halt_q ? T_HALT : ring;

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer: a 6-state one-hot ring counter (T1..T6) plus instruction decode that produces the 12-bit control word for the whole datapath. It sits directly upstream of every general-purpose register (A, B, IR, OUT) and drives their active-low load strobes. It also drives the PC, MAR, RAM and ALU control lines. It consumes the opcode nibble from the instruction register and raises a sticky halt.

## Interface
Parameters: none; widths are fixed by the SAP-1 architecture.

Ports:
- clk_i  input  1  system clock; all state changes on rising edge
- rstn_i  input  1  reset; one clock; asynchronous, active-low
- opcode_i  input  4  IR upper nibble (IR bits 7:4)
- cp_o  output  1  PC increment, active-high
- ep_o  output  1  PC drives bus, active-high
- lm_o  output  1  MAR load, active-low
- ce_o  output  1  RAM drives bus, active-low
- li_o  output  1  IR load, active-low
- ei_o  output  1  IR low nibble drives bus, active-high
- la_o  output  1  A load, active-low
- ea_o  output  1  A drives bus, active-high
- su_o  output  1  ALU subtract select, active-high
- eu_o  output  1  ALU drives bus, active-high
- lb_o  output  1  B load, active-low
- lo_o  output  1  OUT load, active-low
- hlt_o  output  1  halted, active-high, sticky
- t_state_o  output  6  one-hot T-state (bit0 = T1), debug/visibility

## Operation
Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. All other opcodes are NOPs.

Inactive control word (IDLE_CW) means all active-low lines = 1 and all active-high lines = 0.

The control word is Moore-style: it is decoded from the current T-state. In T4..T6 it is also decoded from opcode_i. Any line not listed for a state is inactive.
- T1: ep, lm.
- T2: cp.
- T3: ce, li.
- T4:
  - LDA/ADD/SUB: ei, lm.
  - OUT: ea, lo.
  - HLT: enter HALT (see below).
  - NOP: none.
- T5:
  - LDA: ce, la.
  - ADD/SUB: ce, lb.
  - Others: none.
- T6:
  - ADD: eu, la.
  - SUB: eu, su, la.
  - Others: none.

State sequence:
- T1→T2→…→T6→T1, one step per clock.
- HALT is an extra state, entered from T4 when opcode_i = HLT.
- The transition is registered. The T4 cycle with HLT outputs IDLE_CW.
- HALT outputs IDLE_CW, hlt_o = 1 and t_state_o = 6'b0. It is left only by reset.

Invariant: at most one bus driver is active per cycle (ep, !ce, ei, ea, eu).

## Timing
- Reset, asynchronous: state = T1, so t_state_o = 6'b000001 and hlt_o = 0.
- During reset the control word is forced to IDLE_CW, not to the T1 decode. This prevents the MAR loading while rstn_i is low.
- First T1 decode appears in the first cycle after rstn_i deasserts.
- Each instruction takes exactly 6 cycles; fetch is T1..T3.
- Strobes are valid for the whole cycle. Downstream registers sample them at the rising edge that ends the cycle.
- IR captures the bus at the end of T3, so opcode_i is stable from T4.
- opcode_i is ignored in T1..T3. Changes to it in T1..T3 must not affect outputs.
- Reset mid-instruction (any T-state or HALT): immediate return to T1 with IDLE_CW; no partial strobes.
- rstn_i and a T6→T1 wrap in the same cycle: reset wins. The result is identical either way.

## Structure
- Shared package sap1_pkg holds:
  - opcode constants;
  - T-state one-hot encodings and the HALT encoding;
  - control-word bit indices;
  - IDLE_CW;
  - the 12-bit control-word type.
- The datapath and the bench reuse the package.
- Sub-module ring_counter: 6-bit one-hot rotate with async active-low reset to 6'b000001 and a hold_i input. Hold is used for HALT; HALT is tracked by a separate halt flop in the parent.
- Decode is a combinational block in controller_sequencer.

## Test plan
- **Reset:** drive rstn_i = 0 in mid-T4 of an ADD. Required: outputs go to IDLE_CW and t_state_o = 6'b000001 asynchronously. After release, T1 shows ep = 1, lm_o = 0.
- **LDA (opcode_i = 4'h0 from T4):**
  - T1 ep/lm; T2 cp; T3 ce/li.
  - T4 ei = 1, lm_o = 0; T5 ce_o = 0, la_o = 0; T6 IDLE_CW.
  - Back to T1 on the 7th cycle.
- **ADD then SUB:**
  - ADD T5: lb_o = 0, ce_o = 0. ADD T6: eu = 1, la_o = 0, su = 0.
  - SUB T6: eu = 1, su = 1, la_o = 0.
- **OUT (4'hE):** T4 ea = 1, lo_o = 0. T5 and T6 idle.
- **HLT (4'hF):** T4 is idle, then hlt_o = 1 and t_state_o = 0, held for 20+ cycles with IDLE_CW. A later reset returns to T1 with hlt_o = 0.
- **Undefined opcode plus invariants:**
  - Opcode 4'h7: T4..T6 idle.
  - Randomise opcode_i during T1..T3 and check there is no effect.
  - Assert the single-bus-driver invariant every cycle.
